calc_dispatch_sched: RTL

CALC_DISPATCH_SCHED -- requirements
Module: calc_dispatch_sched

---
 rtl/calc_disp_pkg.sv | 23 ++
 rtl/calc_rr_arb4.sv | 61 ++++++
 rtl/calc_dispatch_sched.sv | 136 +++++++++++++
 3 files changed

// File: rtl/calc_disp_pkg.sv
// Shared constants, port FSM encoding and command-class helper for the
// two-ALU dispatch scheduler.
package calc_disp_pkg;

    localparam int         NUM_PORTS    = 4;
    localparam logic [3:0] ALU1_MAX_CMD = 4'b0011;
    localparam int         CMD_W        = 4;
    localparam int         TAG_W        = 2;
    localparam int         PORT_W       = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PEND  = 2'b01,
        ST_INFLT = 2'b10
    } port_state_e;

    // Command 0 is never held, so any held command above max_cmd is ALU2 work.
    function automatic logic is_alu1_cmd(input logic [CMD_W-1:0] cmd,
                                         input logic [CMD_W-1:0] max_cmd);
        return (cmd != '0) && (cmd <= max_cmd);
    endfunction

endpackage

// File: rtl/calc_rr_arb4.sv
// Four-request round-robin arbiter; a winner that was offered but not taken
// is held until the consumer accepts it.
module calc_rr_arb4
    import calc_disp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        req,
    input  logic              rdy,
    output logic              vld,
    output logic [PORT_W-1:0] grant
);

    logic [PORT_W-1:0] ptr_reg, ptr_next;
    logic              lock_reg, lock_next;
    logic [PORT_W-1:0] lock_idx_reg, lock_idx_next;
    logic              found;
    logic [PORT_W-1:0] search_idx;
    logic [PORT_W-1:0] cand;

    always_comb begin
        found      = 1'b0;
        search_idx = ptr_reg;
        cand       = ptr_reg;
        for (int i = 0; i < 4; i++) begin
            cand = ptr_reg + PORT_W'(i);
            if (!found && req[cand]) begin
                found      = 1'b1;
                search_idx = cand;
            end
        end
    end

    // Replay the stalled winner instead of re-searching.
    always_comb begin
        if (lock_reg && req[lock_idx_reg]) begin
            vld   = 1'b1;
            grant = lock_idx_reg;
        end else begin
            vld   = found;
            grant = search_idx;
        end
    end

    assign ptr_next      = (vld && rdy) ? grant + PORT_W'(1) : ptr_reg;
    assign lock_next     = vld && !rdy;
    assign lock_idx_next = grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg      <= '0;
            lock_reg     <= 1'b0;
            lock_idx_reg <= '0;
        end else begin
            ptr_reg      <= ptr_next;
            lock_reg     <= lock_next;
            lock_idx_reg <= lock_idx_next;
        end
    end

endmodule

// File: rtl/calc_dispatch_sched.sv
// Per-port command holding FSMs feeding two independently arbitrated ALUs,
// with completion tracking and a sticky bad-completion flag.
module calc_dispatch_sched
    import calc_disp_pkg::*;
#(
    parameter int         NUM_PORTS    = calc_disp_pkg::NUM_PORTS,
    parameter logic [3:0] ALU1_MAX_CMD = calc_disp_pkg::ALU1_MAX_CMD
) (
    input  logic                       c_clk,
    input  logic                       reset,
    input  logic [NUM_PORTS-1:0]       req_vld,
    input  logic [NUM_PORTS*CMD_W-1:0] req_cmd,
    input  logic [NUM_PORTS*TAG_W-1:0] req_tag,
    output logic [NUM_PORTS-1:0]       req_rdy,
    output logic                       alu1_in_vld,
    output logic [CMD_W-1:0]           alu1_in_cmd,
    output logic [PORT_W-1:0]          alu1_in_port,
    output logic [TAG_W-1:0]           alu1_in_tag,
    input  logic                       alu1_in_rdy,
    output logic                       alu2_in_vld,
    output logic [CMD_W-1:0]           alu2_in_cmd,
    output logic [PORT_W-1:0]          alu2_in_port,
    output logic [TAG_W-1:0]           alu2_in_tag,
    input  logic                       alu2_in_rdy,
    input  logic                       alu1_done,
    input  logic [PORT_W-1:0]          alu1_done_port,
    input  logic                       alu2_done,
    input  logic [PORT_W-1:0]          alu2_done_port,
    output logic [NUM_PORTS-1:0]       port_busy,
    output logic                       err_bad_done
);

    logic [NUM_PORTS-1:0]       elig1, elig2, inflt;
    logic [NUM_PORTS*CMD_W-1:0] hold_cmd_flat;
    logic [NUM_PORTS*TAG_W-1:0] hold_tag_flat;
    logic [PORT_W-1:0]          grant1, grant2;
    logic                       bad_done;
    logic                       err_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            port_state_e      state_reg, state_next;
            logic [CMD_W-1:0] cmd_reg, cmd_next;
            logic [TAG_W-1:0] tag_reg, tag_next;
            logic [CMD_W-1:0] in_cmd;
            logic             done_hit, disp_hit;

            assign in_cmd   = req_cmd[gi*CMD_W +: CMD_W];
            assign done_hit = (alu1_done && alu1_done_port == PORT_W'(gi)) ||
                              (alu2_done && alu2_done_port == PORT_W'(gi));
            assign disp_hit = (alu1_in_vld && alu1_in_rdy && grant1 == PORT_W'(gi)) ||
                              (alu2_in_vld && alu2_in_rdy && grant2 == PORT_W'(gi));

            always_comb begin
                state_next = state_reg;
                cmd_next   = cmd_reg;
                tag_next   = tag_reg;
                case (state_reg)
                    ST_IDLE: begin
                        // A zero command is accepted but simply discarded.
                        if (req_vld[gi] && in_cmd != '0) begin
                            state_next = ST_PEND;
                            cmd_next   = in_cmd;
                            tag_next   = req_tag[gi*TAG_W +: TAG_W];
                        end
                    end
                    ST_PEND:  if (disp_hit) state_next = ST_INFLT;
                    ST_INFLT: if (done_hit) state_next = ST_IDLE;
                    default:  state_next = ST_IDLE;
                endcase
            end

            always_ff @(posedge c_clk or posedge reset) begin
                if (reset) begin
                    state_reg <= ST_IDLE;
                    cmd_reg   <= '0;
                    tag_reg   <= '0;
                end else begin
                    state_reg <= state_next;
                    cmd_reg   <= cmd_next;
                    tag_reg   <= tag_next;
                end
            end

            assign req_rdy[gi]   = (state_reg == ST_IDLE) && !reset;
            assign port_busy[gi] = (state_reg != ST_IDLE);
            assign inflt[gi]     = (state_reg == ST_INFLT);
            assign elig1[gi]     = (state_reg == ST_PEND) && is_alu1_cmd(cmd_reg, ALU1_MAX_CMD);
            assign elig2[gi]     = (state_reg == ST_PEND) && !is_alu1_cmd(cmd_reg, ALU1_MAX_CMD);
            assign hold_cmd_flat[gi*CMD_W +: CMD_W] = cmd_reg;
            assign hold_tag_flat[gi*TAG_W +: TAG_W] = tag_reg;
        end
    endgenerate

    calc_rr_arb4 u_arb1 (
        .clk   (c_clk),
        .rst   (reset),
        .req   (elig1),
        .rdy   (alu1_in_rdy),
        .vld   (alu1_in_vld),
        .grant (grant1)
    );

    calc_rr_arb4 u_arb2 (
        .clk   (c_clk),
        .rst   (reset),
        .req   (elig2),
        .rdy   (alu2_in_rdy),
        .vld   (alu2_in_vld),
        .grant (grant2)
    );

    // Payload reads as zero whenever nothing is offered.
    assign alu1_in_cmd  = alu1_in_vld ? hold_cmd_flat[grant1*CMD_W +: CMD_W] : '0;
    assign alu1_in_tag  = alu1_in_vld ? hold_tag_flat[grant1*TAG_W +: TAG_W] : '0;
    assign alu1_in_port = alu1_in_vld ? grant1 : '0;
    assign alu2_in_cmd  = alu2_in_vld ? hold_cmd_flat[grant2*CMD_W +: CMD_W] : '0;
    assign alu2_in_tag  = alu2_in_vld ? hold_tag_flat[grant2*TAG_W +: TAG_W] : '0;
    assign alu2_in_port = alu2_in_vld ? grant2 : '0;

    always_comb begin
        bad_done = 1'b0;
        if (alu1_done && !inflt[alu1_done_port]) bad_done = 1'b1;
        if (alu2_done && !inflt[alu2_done_port]) bad_done = 1'b1;
        if (alu1_done && alu2_done && alu1_done_port == alu2_done_port) bad_done = 1'b1;
    end

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) err_reg <= 1'b0;
        else       err_reg <= err_reg | bad_done;
    end

    assign err_bad_done = err_reg;

endmodule
